// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter_pkg: register offsets and ID constants shared by the
// external interrupt arbiter and its per-source gateways.
package irq_arbiter_pkg;

  localparam int ID_W = 4;

  localparam logic [ID_W-1:0] ID_NONE = '0;

  localparam logic [7:0] REG_PRIO    = 8'h00;
  localparam logic [7:0] REG_PENDING = 8'h40;
  localparam logic [7:0] REG_ENABLE  = 8'h44;
  localparam logic [7:0] REG_THRESH  = 8'h48;
  localparam logic [7:0] REG_CLAIM   = 8'h4C;
  localparam logic [7:0] REG_EDGE    = 8'h50;

endpackage

// File: rtl/irq_gateway.sv
// irq_gateway: one source's pending/in_flight state.
// IRQ_ARBITER_EDGE_EN adds rising-edge detection and a held edge.
module irq_gateway (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  input  logic claim_i,
  input  logic complete_i,
`ifdef IRQ_ARBITER_EDGE_EN
  input  logic edge_i,
`endif
  output logic pending_o,
  output logic in_flight_o
);

  logic idle;
  logic set_req;

  assign idle = ~pending_o & ~in_flight_o;

`ifdef IRQ_ARBITER_EDGE_EN
  logic src_q;
  logic held_q;
  logic rise;

  assign rise    = src_i & ~src_q;
  assign set_req = edge_i ? (rise | held_q) : src_i;

  // Previous src level and an edge seen while in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q  <= 1'b0;
      held_q <= 1'b0;
    end else begin
      src_q <= src_i;
      if (edge_i && rise && in_flight_o)
        held_q <= 1'b1;
      else if (idle && set_req)
        held_q <= 1'b0;
    end
  end
`else
  assign set_req = src_i;
`endif

  // Claim beats a new request; complete ends the in-flight window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_o   <= 1'b0;
      in_flight_o <= 1'b0;
    end else begin
      if (claim_i)
        pending_o <= 1'b0;
      else if (idle && set_req)
        pending_o <= 1'b1;

      if (claim_i)
        in_flight_o <= 1'b1;
      else if (complete_i)
        in_flight_o <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: gateways, priority arbiter and register port for MEIP.
// IRQ_ARBITER_EDGE_EN enables per-source edge-triggered mode (0x50).
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [7:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               ack_o,
  output logic               mip_external_o
);

  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [NUM_SRC-1:0] enable_q;
  logic [PRIO_W-1:0]  thresh_q;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_flight;
  logic [NUM_SRC-1:0] claim_vec;
  logic [NUM_SRC-1:0] cmpl_vec;
  logic [ID_W-1:0]    best_id_q;
  logic [ID_W-1:0]    best_id_d;
  logic [PRIO_W-1:0]  best_prio_q;
  logic [PRIO_W-1:0]  best_prio_d;
  logic               rd_req;
  logic               wr_req;
  logic               prio_hit;
  logic [3:0]         prio_idx;
  logic [31:0]        rd_data;
  logic               unused_wdata;

`ifdef IRQ_ARBITER_EDGE_EN
  logic [NUM_SRC-1:0] edge_q;
`endif

  assign rd_req   = req_i & ~we_i;
  assign wr_req   = req_i & we_i;
  assign prio_idx = addr_i[5:2];
  assign prio_hit = (addr_i[7:6] == REG_PRIO[7:6])
                  && (addr_i[1:0] == 2'b00);

  assign unused_wdata = ^wdata_i;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
    irq_gateway u_gw (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .src_i       (src_i[g]),
      .claim_i     (claim_vec[g]),
      .complete_i  (cmpl_vec[g]),
`ifdef IRQ_ARBITER_EDGE_EN
      .edge_i      (edge_q[g]),
`endif
      .pending_o   (pending[g]),
      .in_flight_o (in_flight[g])
    );
  end

  // Claim only takes a source whose pending bit survived; complete
  // only hits a source that is in flight.
  always_comb begin
    claim_vec = '0;
    cmpl_vec  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_vec[i] = rd_req
                  && (addr_i == REG_CLAIM)
                  && (best_id_q == ID_W'(i + 1))
                  && pending[i];
      cmpl_vec[i]  = wr_req
                  && (addr_i == REG_CLAIM)
                  && (wdata_i[ID_W-1:0] == ID_W'(i + 1))
                  && in_flight[i];
    end
  end

  // Highest priority wins; strict compare keeps the lowest ID on ties
  // and never lets priority 0 win.
  always_comb begin
    best_id_d   = ID_NONE;
    best_prio_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending[i] && enable_q[i]
          && (prio_q[i] > best_prio_d)) begin
        best_id_d   = ID_W'(i + 1);
        best_prio_d = prio_q[i];
      end
    end
  end

  // Read data mux; unmapped offsets read zero.
  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      prio_hit: begin
        for (int i = 0; i < NUM_SRC; i++)
          if (prio_idx == 4'(i))
            rd_data = 32'(prio_q[i]);
      end
      (addr_i == REG_PENDING): rd_data = 32'(pending);
      (addr_i == REG_ENABLE):  rd_data = 32'(enable_q);
      (addr_i == REG_THRESH):  rd_data = 32'(thresh_q);
      (addr_i == REG_CLAIM):
        rd_data = (|claim_vec) ? 32'(best_id_q) : '0;
`ifdef IRQ_ARBITER_EDGE_EN
      (addr_i == REG_EDGE):    rd_data = 32'(edge_q);
`else
      (addr_i == REG_EDGE):    rd_data = '0;
`endif
      default:                 rd_data = '0;
    endcase
  end

  // Software-writable configuration registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SRC; i++)
        prio_q[i] <= '0;
      enable_q <= '0;
      thresh_q <= '0;
    end else if (wr_req) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (prio_hit && (prio_idx == 4'(i)))
          prio_q[i] <= wdata_i[PRIO_W-1:0];
      if (addr_i == REG_ENABLE)
        enable_q <= wdata_i[NUM_SRC-1:0];
      if (addr_i == REG_THRESH)
        thresh_q <= wdata_i[PRIO_W-1:0];
    end
  end

`ifdef IRQ_ARBITER_EDGE_EN
  // Per-source trigger mode select.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      edge_q <= '0;
    else if (wr_req && (addr_i == REG_EDGE))
      edge_q <= wdata_i[NUM_SRC-1:0];
  end
`endif

  // Registered best, MEIP and one-cycle register response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      best_id_q      <= ID_NONE;
      best_prio_q    <= '0;
      mip_external_o <= 1'b0;
      ack_o          <= 1'b0;
      rdata_o        <= '0;
    end else begin
      best_id_q      <= best_id_d;
      best_prio_q    <= best_prio_d;
      mip_external_o <= (best_id_q != ID_NONE)
                     && (best_prio_q > thresh_q);
      ack_o          <= req_i;
      rdata_o        <= rd_req ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed and random stimulus against a
// behavioural reference of the interrupt arbiter.
module tb_irq_arbiter;

  localparam int N  = 8;
  localparam int PW = 3;
`ifdef IRQ_ARBITER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif
  localparam int PMASK = (1 << PW) - 1;
  localparam int NMASK = (1 << N) - 1;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic [N-1:0] src   = '0;
  logic         req   = 1'b0;
  logic         we    = 1'b0;
  logic [7:0]   addr  = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         ack;
  logic         mip;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_arbiter #(.NUM_SRC(N), .PRIO_W(PW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .src_i          (src),
    .req_i          (req),
    .we_i           (we),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .rdata_o        (rdata),
    .ack_o          (ack),
    .mip_external_o (mip)
  );

  // Reference state
  int m_prio [N];
  bit m_pend [N];
  bit m_infl [N];
  bit m_held [N];
  bit m_srcq [N];
  int m_en, m_thr, m_edge;
  int m_bid, m_bp, m_rdata;
  bit m_ack, m_mip;

  function automatic void chk(string name, logic [31:0] got,
                              logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endfunction

  // Max priority among candidates, then the lowest ID at that level.
  function automatic void ref_best(output int id, output int p);
    p  = 0;
    id = 0;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_en[i] && m_prio[i] > p)
        p = m_prio[i];
    if (p != 0)
      for (int i = N - 1; i >= 0; i--)
        if (m_pend[i] && m_en[i] && m_prio[i] == p)
          id = i + 1;
  endfunction

  function automatic int ref_read(logic [7:0] a);
    int v;
    v = 0;
    if (a < 8'h40 && a % 4 == 0 && a / 4 < N)
      v = m_prio[a / 4];
    else if (a == 8'h40) begin
      for (int i = 0; i < N; i++)
        if (m_pend[i]) v += (1 << i);
    end else if (a == 8'h44) v = m_en;
    else if (a == 8'h48) v = m_thr;
    else if (a == 8'h4C)
      v = (m_bid != 0 && m_pend[m_bid - 1]) ? m_bid : 0;
    else if (a == 8'h50) v = EDGE_EN ? m_edge : 0;
    return v;
  endfunction

  // Reference update on every edge, from pre-edge state.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_prio[i] = 0;
        m_pend[i] = 0;
        m_infl[i] = 0;
        m_held[i] = 0;
        m_srcq[i] = 0;
      end
      m_en = 0; m_thr = 0; m_edge = 0;
      m_bid = 0; m_bp = 0; m_rdata = 0;
      m_ack = 0; m_mip = 0;
    end else begin
      int nid, np, rv, cid;
      bit nmip, rise, hit;
      bit opend [N];
      bit oinfl [N];
      bit oheld [N];
      nmip = (m_bid != 0) && (m_bp > m_thr);
      ref_best(nid, np);
      rv = (req && !we) ? ref_read(addr) : 0;
      opend = m_pend;
      oinfl = m_infl;
      oheld = m_held;
      for (int i = 0; i < N; i++) begin
        rise = src[i] && !m_srcq[i];
        if (m_edge[i] && rise && oinfl[i]) m_held[i] = 1;
        hit = m_edge[i] ? (rise || oheld[i]) : src[i];
        if (!opend[i] && !oinfl[i] && hit) begin
          m_pend[i] = 1;
          m_held[i] = 0;
        end
        m_srcq[i] = src[i];
      end
      if (req && !we && addr == 8'h4C && rv != 0) begin
        m_pend[rv - 1] = 0;
        m_infl[rv - 1] = 1;
      end
      if (req && we) begin
        if (addr == 8'h4C) begin
          cid = int'(wdata[3:0]);
          if (cid >= 1 && cid <= N && oinfl[cid - 1])
            m_infl[cid - 1] = 0;
        end
        if (addr < 8'h40 && addr % 4 == 0 && addr / 4 < N)
          m_prio[addr / 4] = int'(wdata) & PMASK;
        if (addr == 8'h44) m_en = int'(wdata) & NMASK;
        if (addr == 8'h48) m_thr = int'(wdata) & PMASK;
        if (addr == 8'h50 && EDGE_EN)
          m_edge = int'(wdata) & NMASK;
      end
      m_ack   = req;
      m_rdata = rv;
      m_bid   = nid;
      m_bp    = np;
      m_mip   = nmip;
    end
  end

  // Per-cycle comparison against the reference.
  always @(negedge clk) begin
    chk("ack", 32'(ack), 32'(m_ack));
    chk("rdata", rdata, m_rdata);
    chk("mip", 32'(mip), 32'(m_mip));
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input bit w, input logic [7:0] a,
                     input logic [31:0] d,
                     output logic [31:0] r);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    r = rdata;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, a, d, r);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] r);
    bus(1'b0, a, 32'h0, r);
  endtask

  initial begin
    logic [31:0] r;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_mip", 32'(mip), 32'h0);
    for (int a = 0; a <= 'h50; a += 4) begin
      rd(8'(a), r);
      chk("rst_reg", r, 32'h0);
    end

    // single source
    wr(8'h08, 3); wr(8'h44, 32'h04); wr(8'h48, 0);
    src[2] = 1'b1;
    idle(2); chk("lat_early", 32'(mip), 32'h0);
    idle(1); chk("lat_mip", 32'(mip), 32'h1);
    rd(8'h4C, r); chk("claim_single", r, 32'h3);
    idle(2); chk("mip_drop", 32'(mip), 32'h0);
    idle(4); chk("mip_hold", 32'(mip), 32'h0);
    wr(8'h4C, 3);
    idle(3); chk("repend", 32'(mip), 32'h1);
    src[2] = 1'b0;
    idle(1);
    rd(8'h4C, r); chk("claim_again", r, 32'h3);
    wr(8'h4C, 3);

    // priority and ties
    wr(8'h00, 2); wr(8'h04, 5); wr(8'h14, 5);
    wr(8'h44, 32'h23);
    src = 8'h23;
    idle(3); rd(8'h4C, r); chk("tie_1st", r, 32'h2);
    idle(3); rd(8'h4C, r); chk("tie_2nd", r, 32'h6);
    idle(3); rd(8'h4C, r); chk("tie_3rd", r, 32'h1);
    src = '0;
    idle(1);
    wr(8'h4C, 2); wr(8'h4C, 6); wr(8'h4C, 1);

    // threshold
    wr(8'h44, 32'h01); wr(8'h48, 2);
    src[0] = 1'b1;
    idle(4); chk("thr_block", 32'(mip), 32'h0);
    rd(8'h4C, r); chk("thr_claim", r, 32'h1);
    wr(8'h4C, 1); wr(8'h48, 1);
    idle(3); chk("thr_pass", 32'(mip), 32'h1);
    src[0] = 1'b0;
    idle(1);
    rd(8'h4C, r); chk("thr_claim2", r, 32'h1);
    wr(8'h4C, 1); wr(8'h48, 0);

    // bad completes
    wr(8'h44, 32'h02);
    src[1] = 1'b1;
    idle(3); rd(8'h4C, r); chk("bad_claim", r, 32'h2);
    src[1] = 1'b0;
    wr(8'h4C, 0); wr(8'h4C, 9); wr(8'h4C, 3);
    src[1] = 1'b1;
    idle(3); chk("bad_mip", 32'(mip), 32'h0);
    rd(8'h40, r); chk("bad_pend", r, 32'h0);
    wr(8'h4C, 2);
    idle(1);
    rd(8'h40, r); chk("good_cmpl", r, 32'h2);
    src[1] = 1'b0;
    idle(1);
    rd(8'h4C, r); chk("good_claim", r, 32'h2);
    wr(8'h4C, 2); wr(8'h44, 0);

    // edge register visibility
    wr(8'h50, 32'hFF);
    rd(8'h50, r);
    chk("edge_reg", r, EDGE_EN ? 32'hFF : 32'h0);
    wr(8'h50, 0);

`ifdef IRQ_ARBITER_EDGE_EN
    wr(8'h50, 32'h08); wr(8'h0C, 4); wr(8'h44, 32'h08);
    src[3] = 1'b1; idle(1); src[3] = 1'b0;
    idle(3); rd(8'h4C, r); chk("edge_c1", r, 32'h4);
    src[3] = 1'b1; idle(1); src[3] = 1'b0;
    idle(1); wr(8'h4C, 4);
    idle(3); rd(8'h4C, r); chk("edge_c2", r, 32'h4);
    wr(8'h4C, 4);
    idle(3); rd(8'h4C, r); chk("edge_c3", r, 32'h0);
    wr(8'h50, 0); wr(8'h44, 0);
`endif

    // random traffic with occasional mid-operation reset
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) src[b] = ~src[b];
      rst   = ($urandom_range(0, 499) == 0);
      req   = 1'($urandom_range(0, 1));
      we    = 1'b0;
      wdata = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: addr = 8'h4C;
        3, 4: begin
          we = 1'b1; addr = 8'h4C;
          wdata = 32'($urandom_range(0, 9));
        end
        5: begin
          we = 1'b1;
          addr = 8'($urandom_range(0, 15) * 4);
        end
        6: begin we = 1'b1; addr = 8'h44; end
        7: begin
          we = 1'b1; addr = 8'h48;
          wdata = 32'($urandom_range(0, 3));
        end
        8: addr = 8'($urandom_range(0, 21) * 4);
        default: begin
          we = 1'($urandom_range(0, 1));
          addr = $urandom_range(0, 1) != 0 ? 8'h50
               : 8'($urandom_range(22, 63) * 4);
        end
      endcase
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    req = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
